// File: rtl/ksa_mp_sched.sv
// Round-robin scheduler sharing one external 8-bit adder for NBYTES-byte adds, LSB byte first.
// Optional KSA_SCHED_OVF_EN adds rsp_ovf (signed overflow of the full-width add).
module ksa_mp_sched #(
  parameter int NREQ   = 4,
  parameter int NBYTES = 4,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int KW    = (NBYTES > 1) ? $clog2(NBYTES) : 1,
  localparam int OPW   = 8 * NBYTES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_cin,
  input  logic [7:0]          add_sum,
  input  logic                add_cout,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [OPW-1:0]      rsp_sum,
`ifdef KSA_SCHED_OVF_EN
  output logic                rsp_ovf,
`endif
  output logic                rsp_cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic            grant_vld;
  logic            accept;
  logic [OPW-1:0]  op_a_p0, op_b_p0;
  logic [KW-1:0]   k;
  logic            carry_p1;
  logic            last_byte;

  function automatic logic [ID_W-1:0] ptr_next(input logic [ID_W-1:0] g);
    return (g == ID_W'(NREQ - 1)) ? '0 : g + 1'b1;
  endfunction

  // Arbiter: scan downward so the candidate closest to rr_ptr is assigned last and wins.
  always_comb begin
    logic [ID_W:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(o);
      if (cand >= (ID_W+1)'(NREQ)) cand = cand - (ID_W+1)'(NREQ);
      if (req_valid[cand[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst && grant_vld) req_ready[grant_idx] = 1'b1;
  end

  assign accept    = |(req_valid & req_ready);
  assign last_byte = (k == KW'(NBYTES - 1));
  assign rsp_valid = (state == DONE);
  assign add_a     = (state == RUN) ? op_a_p0[{k, 3'b000} +: 8] : 8'h00;
  assign add_b     = (state == RUN) ? op_b_p0[{k, 3'b000} +: 8] : 8'h00;
  assign add_cin   = (state == RUN) ? carry_p1 : 1'b0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_byte) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p0: operands captured once at accept; requesters may change them afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a_p0 <= req_a[grant_idx*OPW +: OPW];
      op_b_p0 <= req_b[grant_idx*OPW +: OPW];
    end
  end

  // Stage p1: byte-serial accumulation with the carry fed back through carry_p1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      k        <= '0;
      carry_p1 <= 1'b0;
      rsp_sum  <= '0;
      rsp_id   <= '0;
      rsp_cout <= 1'b0;
`ifdef KSA_SCHED_OVF_EN
      rsp_ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          rsp_id   <= grant_idx;
          k        <= '0;
          carry_p1 <= 1'b0;
          rr_ptr   <= ptr_next(grant_idx);
        end
        RUN: begin
          rsp_sum[{k, 3'b000} +: 8] <= add_sum;
          carry_p1 <= add_cout;
          k        <= k + KW'(1);
          if (last_byte) begin
            k        <= '0;
            rsp_cout <= add_cout;
`ifdef KSA_SCHED_OVF_EN
            rsp_ovf  <= (op_a_p0[OPW-1] == op_b_p0[OPW-1]) & (add_sum[7] != op_a_p0[OPW-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_mp_sched.sv
// Directed bench for ksa_mp_sched (NREQ=4, NBYTES=4) with a behavioural 8-bit adder.
module tb_ksa_mp_sched;
  localparam int NREQ = 4;
  localparam int NBYTES = 4;
  localparam int W = 8 * NBYTES;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [7:0]        add_a, add_b, add_sum;
  logic              add_cin, add_cout;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
`ifdef KSA_SCHED_OVF_EN
  logic              rsp_ovf;
`endif

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

  ksa_mp_sched #(.NREQ(NREQ), .NBYTES(NBYTES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum),
`ifdef KSA_SCHED_OVF_EN
    .rsp_ovf(rsp_ovf),
`endif
    .rsp_cout(rsp_cout)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    logic       c;
    logic [8:0] t;
    logic [7:0] ab, bb;
    req_valid = '0;
    req_valid[v.id] = 1'b1;
    req_a[v.id*W +: W] = v.a;
    req_b[v.id*W +: W] = v.b;
    rsp_ready = 1'b1;
    #1;
    check("req_ready_grant", req_ready, 64'(1 << v.id));
    tick();
    req_valid = '0;
    req_a = ~req_a;
    req_b = ~req_b;
    c = 1'b0;
    for (int k = 0; k < NBYTES; k++) begin
      #1;
      ab = v.a[k*8 +: 8];
      bb = v.b[k*8 +: 8];
      check("run_add_a", add_a, ab);
      check("run_add_b", add_b, bb);
      check("run_add_cin", add_cin, c);
      check("run_no_valid", rsp_valid, 0);
      t = {1'b0, ab} + {1'b0, bb} + {8'b0, c};
      c = t[8];
      tick();
    end
    check("latency_valid", rsp_valid, 1);
    check("rsp_sum", rsp_sum, v.sum);
    check("rsp_cout", rsp_cout, v.cout);
    check("rsp_id", rsp_id, v.id);
`ifdef KSA_SCHED_OVF_EN
    check("rsp_ovf", rsp_ovf, v.ovf);
`endif
    tick();
    check("valid_drop", rsp_valid, 0);
  endtask

  initial begin
    logic [31:0] ra[NREQ];
    logic [31:0] rb[NREQ];
    logic        seen;
    int          cyc;

    vecs[0] = '{0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{3, 32'h12345678, 32'h9ABCDEF0, 32'hACF13568, 1'b0, 1'b0};
    vecs[4] = '{0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
    vecs[5] = '{1, 32'hDEADBEEF, 32'h21524111, 32'h00000000, 1'b1, 1'b0};

    rst = 1'b1;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_cin", add_cin, 0);
    rst = 1'b0;
    req_valid = '0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Abort a transaction from requester 2 while byte 2 is on the adder.
    req_valid = 4'b0100;
    req_a[2*W +: W] = 32'h11111111;
    req_b[2*W +: W] = 32'h22222222;
    #1;
    check("abort_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    tick();
    check("abort_in_run", add_a, 8'h11);
    rst = 1'b1;
    req_valid = '1;
    #1;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_add_a", add_a, 0);
    check("abort_add_b", add_b, 0);
    check("abort_add_cin", add_cin, 0);
    check("abort_req_ready", req_ready, 0);
    check("abort_rsp_sum", rsp_sum, 0);
    check("abort_rsp_id", rsp_id, 0);
    tick();
    rst = 1'b0;
    req_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    check("abort_no_rsp", seen, 0);

    // Round robin with all requesters asserting.
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = 32'(i) * 32'h01000000 + 32'h000000F0 + 32'(i);
      rb[i] = 32'h00000010 + 32'(i) * 32'h00100000;
      req_a[i*W +: W] = ra[i];
      req_b[i*W +: W] = rb[i];
    end
    req_valid = '1;
    for (int t = 0; t < 5; t++) begin
      #1;
      check("rr_grant", req_ready, 64'(1 << (t % NREQ)));
      tick();
      cyc = 0;
      while (!rsp_valid && cyc < 20) begin
        tick();
        cyc++;
      end
      check("rr_rsp_valid", rsp_valid, 1);
      check("rr_rsp_id", rsp_id, t % NREQ);
      check("rr_rsp_sum", rsp_sum, ra[t % NREQ] + rb[t % NREQ]);
      tick();
    end

    // Back-pressure: response held for 10 cycles with rsp_ready low.
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    req_a[0 +: W] = 32'h01020304;
    req_b[0 +: W] = 32'h10203040;
    #1;
    check("bp_grant", req_ready, 4'b0001);
    tick();
    req_valid = '1;
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("bp_rsp_valid", rsp_valid, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_sum", rsp_sum, 32'h11223344);
      check("bp_hold_id", rsp_id, 0);
      check("bp_hold_cout", rsp_cout, 0);
      check("bp_hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_valid", rsp_valid, 0);
    check("bp_next_grant", req_ready, 4'b0010);
    tick();
    check("bp_next_run", add_a, 8'hF1);
    req_valid = '0;
    for (int i = 0; i < 8; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
